// File: rtl/ahb_client_arbiter.sv
// Round-robin arbiter that multiplexes NUM_CH client requests onto one AHB master port.
// Grant registered one cycle after request; clients hold requests until ch_dfb/ch_err; timeout or error parks in ERR until err_clr.
module ahb_client_arbiter #(
  parameter int NUM_CH  = 3,
  parameter int PIX_W   = 20,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [2*NUM_CH-1:0]       ch_mode,
  input  logic [PIX_W*NUM_CH-1:0]   ch_pixNum,
  input  logic [DATA_W*NUM_CH-1:0]  ch_wdata,
  input  logic [2*NUM_CH-1:0]       ch_size,
  input  logic                      data_feedback,
  input  logic [DATA_W-1:0]         rdata,
  input  logic                      error,
  input  logic                      err_clr,
  output logic [1:0]                mode,
  output logic [PIX_W-1:0]          pixNum,
  output logic [DATA_W-1:0]         wdata,
  output logic [1:0]                size,
  output logic [$clog2(NUM_CH)-1:0] startAddr_sel,
  output logic [NUM_CH-1:0]         ch_dfb,
  output logic [DATA_W-1:0]         ch_rdata,
  output logic [NUM_CH-1:0]         ch_err,
  output logic                      busy,
  output logic                      fault
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_ERR} state_t;

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             tmo;
  logic [NUM_CH-1:0] elig;
  logic             sel_vld;
  logic [SEL_W-1:0] sel_idx;
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] next_ptr;

  // The channel just completed is masked while its ch_dfb is high, so a
  // request the client has not yet withdrawn is not granted a second time.
  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      elig[k] = ch_en[k] && !ch_dfb[k] &&
                (ch_mode[2*k +: 2] == 2'b01 || ch_mode[2*k +: 2] == 2'b10);
    end
  end

  // Scanning from the far end lets the lowest offset from rr_ptr win last.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = SEL_W'((int'(rr_ptr) + i) % NUM_CH);
      if (elig[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  assign next_ptr = (startAddr_sel == SEL_W'(NUM_CH - 1)) ? '0 : startAddr_sel + SEL_W'(1);
  assign cnt_inc  = (cnt == CNT_W'(TIMEOUT)) ? cnt : cnt + CNT_W'(1);
  assign tmo      = (cnt_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      cnt           <= '0;
      mode          <= 2'b00;
      pixNum        <= '0;
      wdata         <= '0;
      size          <= 2'b00;
      startAddr_sel <= '0;
      ch_dfb        <= '0;
      ch_err        <= '0;
      ch_rdata      <= '0;
      busy          <= 1'b0;
      fault         <= 1'b0;
    end else begin
      ch_dfb <= '0;
      ch_err <= '0;
      case (state)
        S_IDLE: begin
          if (sel_vld) begin
            mode          <= ch_mode[int'(sel_idx)*2 +: 2];
            pixNum        <= ch_pixNum[int'(sel_idx)*PIX_W +: PIX_W];
            wdata         <= ch_wdata[int'(sel_idx)*DATA_W +: DATA_W];
            size          <= ch_size[int'(sel_idx)*2 +: 2];
            startAddr_sel <= sel_idx;
            cnt           <= '0;
            busy          <= 1'b1;
            state         <= S_GRANT;
          end
        end
        S_GRANT: state <= S_WAIT;
        S_WAIT: begin
          // A fault wins over a simultaneous completion.
          if (error || tmo) begin
            ch_err[startAddr_sel] <= 1'b1;
            mode                  <= 2'b00;
            busy                  <= 1'b0;
            fault                 <= 1'b1;
            state                 <= S_ERR;
          end else if (data_feedback) begin
            ch_dfb[startAddr_sel] <= 1'b1;
            ch_rdata              <= rdata;
            mode                  <= 2'b00;
            busy                  <= 1'b0;
            rr_ptr                <= next_ptr;
            state                 <= S_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_ERR: begin
          if (err_clr) begin
            fault  <= 1'b0;
            rr_ptr <= next_ptr;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
